seven_seg_mux_driver: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 37 +++
 rtl/seven_seg_mux_driver_decode.sv | 33 +++
 rtl/seven_seg_mux_driver.sv | 157 +++++++++++++++
 tb/tb_seven_seg_mux_driver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants, FSM state type and helpers for the seven-segment driver
package seven_seg_pkg;

  // Active-low segment codes, bit order g..a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // 10^digits, saturated at 2^value_w so it always fits in value_w+1 bits;
  // a saturated limit is unreachable by any value_w-bit input.
  function automatic logic [63:0] pow10_limit(input int digits, input int value_w);
    logic [63:0] p;
    logic [63:0] cap;
    p   = 64'd1;
    cap = 64'd1 << value_w;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return (p > cap) ? cap : p;
  endfunction

endpackage

// File: rtl/seven_seg_mux_driver_decode.sv
// rtl/seven_seg_mux_driver_decode.sv - BCD nibble to active-low segment code with blank and dash overrides
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] segs
);

  // Dash wins over blanking so an overflow shows dashes on every digit
  always_comb begin
    segs = SEG_BLANK;
    if (dash) begin
      segs = SEG_DASH;
    end else if (!blank) begin
      case (nibble)
        4'd0:    segs = SEG_0;
        4'd1:    segs = SEG_1;
        4'd2:    segs = SEG_2;
        4'd3:    segs = SEG_3;
        4'd4:    segs = SEG_4;
        4'd5:    segs = SEG_5;
        4'd6:    segs = SEG_6;
        4'd7:    segs = SEG_7;
        4'd8:    segs = SEG_8;
        4'd9:    segs = SEG_9;
        default: segs = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// rtl/seven_seg_mux_driver.sv - binary-to-BCD converter and multiplexed seven-segment scanner
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int VALUE_W       = 14,
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic               busy,
  output logic               overflow,
  output logic [6:0]         segs,
  output logic [DIGITS-1:0]  anodes
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SR_W   = BCD_W + VALUE_W;
  localparam int LIM_W  = VALUE_W + 1;
  localparam int CNT_W  = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);

  localparam logic [LIM_W-1:0]  LIMIT     = LIM_W'(pow10_limit(DIGITS, VALUE_W));
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(VALUE_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_adj;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               ovf_pend_q;
  logic               value_ovf;
  logic [BCD_W-1:0]   disp_q;
  logic               dash_q;
  logic [SCAN_W-1:0]  scan_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DIGITS-1:0]  lz;
  logic [3:0]         cur_nib;
  logic               cur_blank;
  logic [6:0]         cur_segs;

  assign value_ovf = {1'b0, value} >= LIMIT;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: overflowing values skip the conversion entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = value_ovf ? COMMIT : CONV;
      CONV:    if (bit_cnt_q == CNT_LAST) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy is decoded straight from the state register
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Double-dabble pre-shift correction: +3 on every BCD nibble that is 5 or more
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[VALUE_W + 4*i +: 4] >= 4'd5)
        sr_adj[VALUE_W + 4*i +: 4] = sr_q[VALUE_W + 4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture on accepted load, correct-and-shift while converting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (load) begin
          ovf_pend_q <= value_ovf;
          bit_cnt_q  <= '0;
          if (!value_ovf) sr_q <= SR_W'(value);
        end
        CONV: begin
          sr_q      <= sr_adj << 1;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Display register: BCD result or all-dash marker, updated only in COMMIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q   <= '0;
      dash_q   <= 1'b0;
      overflow <= 1'b0;
    end else if (state_q == COMMIT) begin
      disp_q   <= ovf_pend_q ? '0 : sr_q[SR_W-1 -: BCD_W];
      dash_q   <= ovf_pend_q;
      overflow <= ovf_pend_q;
    end
  end

  // Scanner: free-running dwell counter stepping the digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      idx_q      <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  // Leading-zero map: lz[i] is set when digit i and all digits above it are zero
  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp_q[BCD_W-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] & (disp_q[4*i +: 4] == 4'd0);
    end
  end

  assign cur_nib   = disp_q[4*idx_q +: 4];
  assign cur_blank = BLANK_LEADING && (idx_q != '0) && lz[idx_q];

  seven_seg_decode u_decode (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .dash   (dash_q),
    .segs   (cur_segs)
  );

  // Segment and anode outputs registered together from the same index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      segs   <= SEG_BLANK;
      anodes <= '1;
    end else begin
      segs   <= cur_segs;
      anodes <= ~(DIGITS'(1) << idx_q);
    end
  end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// tb/tb_seven_seg_mux_driver.sv - directed self-checking bench for seven_seg_mux_driver
module tb_seven_seg_mux_driver;

  localparam int DIGITS   = 4;
  localparam int VALUE_W  = 14;
  localparam int SCAN_DIV = 4;

  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [6:0] CB = 7'b1111111;
  localparam logic [6:0] CD = 7'b0111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [VALUE_W-1:0] value = '0;
  logic load = 1'b0;

  logic busy, overflow, busy_nb, overflow_nb;
  logic [6:0] segs, segs_nb;
  logic [DIGITS-1:0] anodes, anodes_nb;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seven_seg_mux_driver #(
    .DIGITS(DIGITS), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .overflow(overflow), .segs(segs), .anodes(anodes)
  );

  seven_seg_mux_driver #(
    .DIGITS(DIGITS), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV), .BLANK_LEADING(1'b0)
  ) dut_nb (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy_nb), .overflow(overflow_nb), .segs(segs_nb), .anodes(anodes_nb)
  );

  task automatic do_load(input logic [VALUE_W-1:0] v);
    @(posedge clk); #1;
    value = v;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  task automatic read_digit(input int which, input int i, output logic [6:0] s, output bit ok);
    logic [3:0] one;
    logic [3:0] want;
    one  = 4'b0001;
    want = ~(one << i);
    ok   = 1'b0;
    s    = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (which == 0 && anodes === want) begin s = segs; ok = 1'b1; break; end
      if (which == 1 && anodes_nb === want) begin s = segs_nb; ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [6:0] exp_sg;
    one = 4'b0001;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (segs !== CB) begin n_fail++; $display("FAIL reset_segs got %b want %b", segs, CB); end
    n_checks++; if (anodes !== 4'b1111) begin n_fail++; $display("FAIL reset_anodes got %b want 1111", anodes); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_an = ~(one << (k / 4));
      exp_sg = (k < 4) ? C0 : CB;
      n_checks++;
      if (anodes !== exp_an || segs !== exp_sg) begin
        n_fail++;
        $display("FAIL reset_scan k=%0d got anodes=%b segs=%b want anodes=%b segs=%b", k, anodes, segs, exp_an, exp_sg);
      end
    end
  endtask

  task automatic test_1234();
    int n;
    logic [6:0] s;
    bit ok;
    logic [6:0] e [4];
    e = '{C4, C3, C2, C1};
    do_load(14'd1234);
    count_busy(n);
    n_checks++; if (n != 15) begin n_fail++; $display("FAIL busy_len_1234 got %0d want 15", n); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_1234 got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      read_digit(0, i, s, ok);
      n_checks++;
      if (!ok || s !== e[i]) begin n_fail++; $display("FAIL digit_1234[%0d] got %b (seen=%0d) want %b", i, s, ok, e[i]); end
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [6:0] s;
    bit ok;
    do_load(14'd9999);
    count_busy(n);
    n_checks++; if (n != 15) begin n_fail++; $display("FAIL busy_len_9999 got %0d want 15", n); end
    for (int i = 0; i < 4; i++) begin
      read_digit(0, i, s, ok);
      n_checks++;
      if (!ok || s !== C9) begin n_fail++; $display("FAIL digit_9999[%0d] got %b (seen=%0d) want %b", i, s, ok, C9); end
    end
    do_load(14'd10000);
    count_busy(n);
    n_checks++; if (n != 1) begin n_fail++; $display("FAIL busy_len_10000 got %0d want 1", n); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_10000 got %b want 1", overflow); end
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        read_digit(w, i, s, ok);
        n_checks++;
        if (!ok || s !== CD) begin n_fail++; $display("FAIL dash_10000 inst=%0d digit=%0d got %b (seen=%0d) want %b", w, i, s, ok, CD); end
      end
    end
  endtask

  task automatic test_blank();
    int n;
    logic [6:0] s;
    bit ok;
    logic [6:0] eb [4];
    logic [6:0] en [4];
    eb = '{C7, CB, CB, CB};
    en = '{C7, C0, C0, C0};
    do_load(14'd7);
    count_busy(n);
    n_checks++; if (n != 15) begin n_fail++; $display("FAIL busy_len_7 got %0d want 15", n); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_7 got %b want 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      read_digit(0, i, s, ok);
      n_checks++;
      if (!ok || s !== eb[i]) begin n_fail++; $display("FAIL blank_7[%0d] got %b (seen=%0d) want %b", i, s, ok, eb[i]); end
      read_digit(1, i, s, ok);
      n_checks++;
      if (!ok || s !== en[i]) begin n_fail++; $display("FAIL noblank_7[%0d] got %b (seen=%0d) want %b", i, s, ok, en[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [6:0] s;
    bit ok;
    logic [6:0] e42 [4];
    logic [6:0] e99 [4];
    e42 = '{C2, C4, CB, CB};
    e99 = '{C9, C9, CB, CB};
    do_load(14'd42);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 3) begin value = 14'd99; load = 1'b1; end
      else load = 1'b0;
    end
    load = 1'b0;
    n_checks++; if (n != 15) begin n_fail++; $display("FAIL busy_len_42 got %0d want 15", n); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_not_queued busy got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin
      read_digit(0, i, s, ok);
      n_checks++;
      if (!ok || s !== e42[i]) begin n_fail++; $display("FAIL digit_42[%0d] got %b (seen=%0d) want %b", i, s, ok, e42[i]); end
    end
    do_load(14'd5);
    count_busy(n);
    value = 14'd99;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    count_busy(n);
    n_checks++; if (n != 15) begin n_fail++; $display("FAIL busy_len_99_on_fall got %0d want 15", n); end
    for (int i = 0; i < 4; i++) begin
      read_digit(0, i, s, ok);
      n_checks++;
      if (!ok || s !== e99[i]) begin n_fail++; $display("FAIL digit_99[%0d] got %b (seen=%0d) want %b", i, s, ok, e99[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s;
    logic [6:0] exp_sg;
    bit ok;
    logic [6:0] eb [4];
    logic [6:0] en [4];
    eb = '{C0, CB, CB, CB};
    en = '{C0, C0, C0, C0};
    do_load(14'd8888);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_sg = (anodes === 4'b1110 || anodes === 4'b1101) ? C9 : CB;
      n_checks++;
      if (busy !== 1'b1 || segs !== exp_sg) begin
        n_fail++;
        $display("FAIL conv_no_partial c=%0d got busy=%b segs=%b anodes=%b want busy=1 segs=%b", c, busy, segs, anodes, exp_sg);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_checks++; if (segs !== CB || anodes !== 4'b1111) begin n_fail++; $display("FAIL midrst_outputs got segs=%b anodes=%b want 1111111/1111", segs, anodes); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_digit(0, i, s, ok);
      n_checks++;
      if (!ok || s !== eb[i]) begin n_fail++; $display("FAIL midrst_digit[%0d] got %b (seen=%0d) want %b", i, s, ok, eb[i]); end
      read_digit(1, i, s, ok);
      n_checks++;
      if (!ok || s !== en[i]) begin n_fail++; $display("FAIL midrst_digit_nb[%0d] got %b (seen=%0d) want %b", i, s, ok, en[i]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_1234();
    test_overflow();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
